// File: rtl/regs_tagged.sv
// regs_tagged: architectural register file with per-register rename status (busy + producer tag).
// Latency: reads are combinational from address; issue/CDB/flush updates land on the rising clk edge.
// Backpressure: none; every issue and CDB broadcast is accepted on the edge it is presented.
//
// Ports:
//   clk, rst (async, active-low)
//   R_addr_A/B -> rdata_A/B, busy_A/B, tag_A/B : two issue-stage source reads
//   issue_en, issue_addr, issue_tag            : rename a destination to a producer tag
//   cdb_valid, cdb_tag, cdb_data               : common data bus writeback broadcast
//   flush                                      : clear all busy bits (tags kept)
//   Debug_addr -> Debug_regs                   : value-only debug read, never forwarded
// Optional build macro: REGS_CDB_BYPASS_EN forwards a same-cycle CDB hit onto the read ports.
module regs_tagged #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] R_addr_A,
    input  logic [ADDR_W-1:0] R_addr_B,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic              busy_A,
    output logic              busy_B,
    output logic [TAG_W-1:0]  tag_A,
    output logic [TAG_W-1:0]  tag_B,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] Debug_addr,
    output logic [DATA_W-1:0] Debug_regs
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0][TAG_W-1:0]  tag_q,  tag_d;
    logic [NREG-1:0]             busy_q, busy_d;

    // Next-state: CDB writeback first, then flush/issue override the status.
    // Entry 0 is never written, so it stays at its reset value of zero.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (cdb_valid && busy_q[r] && (tag_q[r] == cdb_tag)) begin
                data_d[r] = cdb_data;
                busy_d[r] = 1'b0;
            end
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (issue_en && (issue_addr == ADDR_W'(r))) begin
                // Issue wins status over a same-edge CDB hit; the data write still lands.
                busy_d[r] = 1'b1;
                tag_d[r]  = issue_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            tag_q  <= '0;
            busy_q <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    // Source read returns {busy, tag, data} from pre-edge state.
    function automatic logic [DATA_W+TAG_W:0] read_port(input logic [ADDR_W-1:0] a);
        logic              b;
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] d;
        b = busy_q[a];
        t = tag_q[a];
        d = data_q[a];
        if (a == '0) begin
            b = 1'b0;
            t = '0;
            d = '0;
        end
`ifdef REGS_CDB_BYPASS_EN
        else if (b && cdb_valid && (t == cdb_tag)) begin
            // Forward the broadcast so the consumer need not wait for the edge.
            b = 1'b0;
            t = '0;
            d = cdb_data;
        end
`endif
        return {b, t, d};
    endfunction

    always_comb begin
        {busy_A, tag_A, rdata_A} = read_port(R_addr_A);
        {busy_B, tag_B, rdata_B} = read_port(R_addr_B);
    end

    assign Debug_regs = (Debug_addr == '0) ? '0 : data_q[Debug_addr];

endmodule

// File: tb/tb_regs_tagged.sv
// tb_regs_tagged: directed plus randomized bench for regs_tagged against a behavioural model.
// Latency: reads checked combinationally in the low clock phase; model advances on each rising edge.
// Backpressure: not applicable.
module tb_regs_tagged;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int TAG_W  = 4;
    localparam int NREG   = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] R_addr_A, R_addr_B, issue_addr, Debug_addr;
    logic [DATA_W-1:0] rdata_A, rdata_B, cdb_data, Debug_regs;
    logic              busy_A, busy_B, issue_en, cdb_valid, flush;
    logic [TAG_W-1:0]  tag_A, tag_B, issue_tag, cdb_tag;

    int vectors;
    int miscompares;

    // Behavioural model state
    logic [DATA_W-1:0] m_data [NREG];
    logic              m_busy [NREG];
    logic [TAG_W-1:0]  m_tag  [NREG];

    regs_tagged #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .R_addr_A   (R_addr_A),
        .R_addr_B   (R_addr_B),
        .rdata_A    (rdata_A),
        .rdata_B    (rdata_B),
        .busy_A     (busy_A),
        .busy_B     (busy_B),
        .tag_A      (tag_A),
        .tag_B      (tag_B),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .issue_tag  (issue_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .flush      (flush),
        .Debug_addr (Debug_addr),
        .Debug_regs (Debug_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Expected source read from the model, given the CDB currently on the bus.
    task automatic m_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                          output logic b, output logic [TAG_W-1:0] t);
        d = m_data[a];
        b = m_busy[a];
        t = m_tag[a];
`ifdef REGS_CDB_BYPASS_EN
        if (b && cdb_valid && t == cdb_tag) begin
            d = cdb_data;
            b = 1'b0;
            t = '0;
        end
`endif
    endtask

    // Apply one edge's worth of rules to the model.
    task automatic m_edge();
        for (int r = 1; r < NREG; r++) begin
            if (cdb_valid && m_busy[r] && m_tag[r] == cdb_tag) begin
                m_data[r] = cdb_data;
                m_busy[r] = 1'b0;
            end
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        end else if (issue_en && issue_addr != 0) begin
            m_busy[issue_addr] = 1'b1;
            m_tag[issue_addr]  = issue_tag;
        end
    endtask

    task automatic idle();
        issue_en  = 1'b0;
        issue_addr = '0;
        issue_tag = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        flush     = 1'b0;
    endtask

    // Inputs already driven (low phase): check reads, clock the edge, advance model.
    task automatic cycle();
        logic [DATA_W-1:0] d;
        logic              b;
        logic [TAG_W-1:0]  t;
        #1;
        m_read(R_addr_A, d, b, t);
        chk("rdata_A", 64'(rdata_A), 64'(d));
        chk("busy_A",  64'(busy_A),  64'(b));
        if (b) chk("tag_A", 64'(tag_A), 64'(t));
        m_read(R_addr_B, d, b, t);
        chk("rdata_B", 64'(rdata_B), 64'(d));
        chk("busy_B",  64'(busy_B),  64'(b));
        if (b) chk("tag_B", 64'(tag_B), 64'(t));
        chk("debug", 64'(Debug_regs), 64'(m_data[Debug_addr]));
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic do_issue(input int a, input int t);
        idle();
        issue_en = 1'b1;
        issue_addr = ADDR_W'(a);
        issue_tag = TAG_W'(t);
        cycle();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_reset();
        rst = 1'b0;
        idle();
        R_addr_A = 5'd5;
        R_addr_B = 5'd31;
        Debug_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rdata_A", 64'(rdata_A), 64'h0);
        chk("reset_busy_B",  64'(busy_B),  64'h0);
        rst = 1'b1;

        // Reset state after release
        #1;
        chk("post_reset_rdata_B", 64'(rdata_B), 64'h0);
        chk("post_reset_tag_A",   64'(tag_A),   64'h0);
        cycle();

        // Issue r3 tag 7, issue to r0 ignored
        do_issue(3, 7);
        do_issue(0, 5);
        idle();
        R_addr_A = 5'd3;
        R_addr_B = 5'd0;
        #1;
        chk("issue_busy_A", 64'(busy_A), 64'h1);
        chk("issue_tag_A",  64'(tag_A),  64'h7);
        chk("issue_rdata_A", 64'(rdata_A), 64'h0);
        chk("r0_busy_B",    64'(busy_B), 64'h0);
        cycle();

        // Multi-match CDB; r4 holds a stale tag 7 but is not busy
        do_issue(4, 7);
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'h7; cdb_data = 32'h4444_4444;
        cycle();
        do_issue(3, 7);
        do_issue(9, 7);
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'h7; cdb_data = 32'hDEAD_BEEF;
        cycle();
        idle();
        R_addr_A = 5'd3;
        R_addr_B = 5'd9;
        Debug_addr = 5'd4;
        #1;
        chk("mm_r3", 64'(rdata_A), 64'hDEAD_BEEF);
        chk("mm_r9", 64'(rdata_B), 64'hDEAD_BEEF);
        chk("mm_r3_busy", 64'(busy_A), 64'h0);
        chk("mm_r4_kept", 64'(Debug_regs), 64'h4444_4444);
        cycle();

        // Same-edge CDB and issue on r5
        do_issue(5, 2);
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'h2; cdb_data = 32'h1234;
        issue_en = 1'b1; issue_addr = 5'd5; issue_tag = 4'h9;
        cycle();
        idle();
        R_addr_A = 5'd5;
        #1;
        chk("coll_rdata", 64'(rdata_A), 64'h1234);
        chk("coll_busy",  64'(busy_A),  64'h1);
        chk("coll_tag",   64'(tag_A),   64'h9);
        cycle();

        // Same-cycle CDB on a busy read
        do_issue(6, 3);
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'h3; cdb_data = 32'hA5A5;
        R_addr_A = 5'd6;
        Debug_addr = 5'd6;
        #1;
`ifdef REGS_CDB_BYPASS_EN
        chk("byp_rdata", 64'(rdata_A), 64'hA5A5);
        chk("byp_busy",  64'(busy_A),  64'h0);
`else
        chk("nobyp_busy", 64'(busy_A), 64'h1);
        chk("nobyp_tag",  64'(tag_A),  64'h3);
`endif
        chk("byp_debug", 64'(Debug_regs), 64'h0);
        cycle();

        // Flush with same-edge issue
        do_issue(7, 12);
        do_issue(8, 13);
        idle();
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd10; issue_tag = 4'h1;
        cycle();
        idle();
        R_addr_A = 5'd7;
        R_addr_B = 5'd10;
        #1;
        chk("flush_r7",  64'(busy_A), 64'h0);
        chk("flush_r10", 64'(busy_B), 64'h0);
        cycle();
        R_addr_A = 5'd8;
        cycle();

        // Asynchronous reset between edges, with issue and CDB pending
        do_issue(12, 6);
        idle();
        R_addr_A = 5'd3;
        R_addr_B = 5'd12;
        issue_en = 1'b1; issue_addr = 5'd11; issue_tag = 4'h6;
        cdb_valid = 1'b1; cdb_tag = 4'h6; cdb_data = 32'hFFFF_0000;
        #2 rst = 1'b0;
        #1;
        chk("arst_rdata_A", 64'(rdata_A), 64'h0);
        chk("arst_busy_B",  64'(busy_B),  64'h0);
        chk("arst_tag_B",   64'(tag_B),   64'h0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();
        R_addr_A = 5'd11;
        cycle();

        // Randomized traffic; narrow tag range so CDB hits and collisions are common
        for (int n = 0; n < 400; n++) begin
            R_addr_A   = ADDR_W'($urandom);
            R_addr_B   = ADDR_W'($urandom);
            Debug_addr = ADDR_W'($urandom);
            issue_en   = 1'($urandom_range(0, 1));
            issue_addr = ADDR_W'($urandom_range(0, 7));
            issue_tag  = TAG_W'($urandom_range(0, 3));
            cdb_valid  = 1'($urandom_range(0, 1));
            cdb_tag    = TAG_W'($urandom_range(0, 3));
            cdb_data   = $urandom;
            flush      = ($urandom_range(0, 15) == 0);
            if (n % 2 == 0) R_addr_A = ADDR_W'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regs_tagged.md
Name: regs_tagged

Overview:
Parametrised architectural register file with per-register Tomasulo rename status (busy bit + producer tag).
- Issue stage reads two source operands, getting value or pending tag for each.
- Issue stage renames a destination to a reservation-station/ROB tag.
- The common data bus (CDB) broadcast writes results into every register still waiting on that tag.
- Replaces the plain two-read/one-write register file in the core.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; NREG = 2**ADDR_W registers, register 0 hard-wired to zero
TAG_W, 4, producer tag width (reservation-station/ROB id)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
R_addr_A  input  ADDR_W  source A address
R_addr_B  input  ADDR_W  source B address
rdata_A  output  DATA_W  source A value
rdata_B  output  DATA_W  source B value
busy_A  output  1  source A pending
busy_B  output  1  source B pending
tag_A  output  TAG_W  producer tag of A, valid when busy_A=1
tag_B  output  TAG_W  producer tag of B, valid when busy_B=1
issue_en  input  1  rename destination this cycle
issue_addr  input  ADDR_W  destination register
issue_tag  input  TAG_W  tag of issuing producer
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB producer tag
cdb_data  input  DATA_W  CDB result
flush  input  1  synchronous clear of all busy bits (mispredict/exception)
Debug_addr  input  ADDR_W  debug read address
Debug_regs  output  DATA_W  debug read data (value only)

Behaviour:
- Reset (rst=0, asynchronous):
  - All data = 0, busy = 0, tags = 0.
  - Outputs settle to 0 combinationally.
  - Reset mid-broadcast or mid-issue discards that update.
- Register 0:
  - Reads value 0, busy 0, tag 0.
  - issue_en to addr 0 is ignored.
  - CDB never writes it.
- Reads are combinational, with zero latency from address.
  - A and B ports are identical in behaviour.
- CDB writeback, on a rising edge with cdb_valid=1:
  - Every register r≠0 with busy[r]=1 and tag[r]==cdb_tag gets data[r] <= cdb_data and busy[r] <= 0.
  - Multiple registers may match; all are updated.
  - Non-busy registers with a stale equal tag are untouched.
- Issue, on a rising edge with issue_en=1 and issue_addr≠0:
  - busy[issue_addr] <= 1, tag[issue_addr] <= issue_tag.
  - Data is unchanged.
- Same-edge issue and CDB on the same register (CDB tag matches the old tag):
  - Data is written with cdb_data.
  - busy stays 1 and tag takes issue_tag; issue wins status.
- Read vs same-cycle issue: reads return pre-issue state, so an instruction reading its own destination sees the old producer.
- flush=1 on an edge:
  - All busy bits cleared; tags unchanged.
  - Same-edge CDB data write still occurs.
  - Same-edge issue is ignored; flush has priority over issue.
- Tag reuse is the issuer's responsibility: the block does not check that issue_tag is free.

Optional Feature:
REGS_CDB_BYPASS_EN
- Defined:
  - If the read register is busy, cdb_valid=1 and cdb_tag equals its tag in the same cycle, the port returns rdata=cdb_data, busy=0, tag=0.
  - This is combinational forwarding, so the consumer does not wait an extra cycle.
- Undefined:
  - Reads show busy=1 with the old tag until the edge after the broadcast.
  - The consumer must snoop the CDB itself.
- Both builds: debug port never bypasses.

Test Plan:
1. Reset: hold rst=0, then release. Read A=5, B=31 -> rdata=0, busy=0, tag=0.
2. Issue and read: issue r3 tag 4'h7. Next cycle read A=3 -> busy_A=1, tag_A=7, rdata_A=0. Read B=0 after issuing r0 -> busy_B=0, rdata_B=0.
3. Multi-match CDB: issue r3 and r9 both tag 7, then CDB tag 7 data 32'hDEADBEEF. Next cycle -> r3=r9=DEADBEEF, both not busy. r4 (tag 7, not busy) keeps its old value.
4. Same-edge collision: r5 busy tag 2. On the same edge, CDB tag 2 data 32'h1234 and issue r5 tag 9. Next cycle -> rdata=32'h1234, busy=1, tag=9.
5. Bypass: r6 busy tag 3, CDB tag 3 data 32'hA5A5 in the read cycle.
   - REGS_CDB_BYPASS_EN defined -> rdata=A5A5, busy=0 the same cycle.
   - Undefined -> busy=1, tag=3 until the next edge.
6. Flush and reset mid-op:
   - r7 and r8 busy; assert flush with issue r10 tag 1. Next cycle -> all busy=0, r10 not busy.
   - Drop rst asynchronously between edges -> outputs 0 immediately.
